// File: rtl/rtc_pkg.sv
// Shared types and helpers for the MM:SS.cc clock time-setting logic.
package rtc_pkg;

  // Encoding is visible on the mode LEDs, so values are fixed.
  typedef enum logic [1:0] {
    StRun    = 2'b00,
    StSetMin = 2'b01,
    StSetSec = 2'b10,
    StCommit = 2'b11
  } rtc_state_e;

  localparam logic [7:0] BcdMaxMs = 8'h59;

  // BCD increment 00..59 with wrap; any invalid BCD value is forced to 00.
  function automatic logic [7:0] bcd_inc_wrap(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = v[7:4];
    units = v[3:0];
    if (tens > 4'd5 || units > 4'd9 || v == BcdMaxMs) begin
      return 8'h00;
    end else if (units == 4'd9) begin
      return {tens + 4'd1, 4'd0};
    end else begin
      return {tens, units + 4'd1};
    end
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchroniser, tick-sampled debounce, press strobe.
module key_debounce #(
  parameter int unsigned DEB_TICKS = 2
) (
  input  logic clk,
  input  logic aclr,
  input  logic tick_i,
  input  logic key_n_i,
  output logic press_o,      // one clk after the accepting tick
  output logic pressed_o,    // accepted-low level
  output logic held_tick_o   // one clk after each further low tick while pressed
);

  localparam int unsigned CntW = $clog2(DEB_TICKS + 1);

  logic [1:0]      sync_q;
  logic            armed_q;
  logic            pressed_q;
  logic            press_q;
  logic            held_tick_q;
  logic [CntW-1:0] low_cnt_q;
  logic            key_low;

  assign key_low = ~sync_q[1];

  // Synchronise the raw key; idles released (high).
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_n_i};
    end
  end

  // Debounce on tick samples; arming needs one high sample so a key held
  // through reset is not taken as a press.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      armed_q     <= 1'b0;
      pressed_q   <= 1'b0;
      press_q     <= 1'b0;
      held_tick_q <= 1'b0;
      low_cnt_q   <= '0;
    end else begin
      press_q     <= 1'b0;
      held_tick_q <= 1'b0;
      if (tick_i) begin
        if (!key_low) begin
          armed_q   <= 1'b1;
          pressed_q <= 1'b0;
          low_cnt_q <= '0;
        end else if (pressed_q) begin
          held_tick_q <= 1'b1;
        end else if (armed_q) begin
          if (low_cnt_q == CntW'(DEB_TICKS - 1)) begin
            pressed_q <= 1'b1;
            press_q   <= 1'b1;
            low_cnt_q <= '0;
          end else begin
            low_cnt_q <= low_cnt_q + 1'b1;
          end
        end
      end
    end
  end

  assign press_o     = press_q;
  assign pressed_o   = pressed_q;
  assign held_tick_o = held_tick_q;

endmodule

// File: rtl/rtc_set_controller.sv
// Time-setting sequencer: freezes the counter chain, edits MM then SS in BCD,
// issues a one-cycle parallel load and drives blink blanking.
module rtc_set_controller
  import rtc_pkg::*;
#(
  parameter int unsigned DEB_TICKS     = 2,
  parameter int unsigned REPEAT_DELAY  = 50,
  parameter int unsigned REPEAT_PERIOD = 10,
  parameter int unsigned BLINK_TICKS   = 25,
  parameter int unsigned TIMEOUT_TICKS = 1000
) (
  input  logic       clk,
  input  logic       aclr,
  input  logic       tick_10ms_i,
  input  logic       key_mode_n_i,
  input  logic       key_inc_n_i,
  input  logic [7:0] cur_min_i,
  input  logic [7:0] cur_sec_i,
  output logic       run_en_o,
  output logic       load_o,
  output logic [7:0] load_min_o,
  output logic [7:0] load_sec_o,
  output logic       load_clr_cc_o,
  output logic [1:0] blank_mask_o,
  output logic [1:0] mode_o
);

  localparam int unsigned RepW   = $clog2(REPEAT_DELAY + 1);
  localparam int unsigned BlinkW = $clog2(BLINK_TICKS + 1);
  localparam int unsigned ToW    = $clog2(TIMEOUT_TICKS + 1);

  logic mode_stb, mode_pressed, mode_held_tick;
  logic inc_press, inc_pressed, inc_held_tick;
  logic unused_mode_lvl;

  key_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_mode (
    .clk        (clk),
    .aclr       (aclr),
    .tick_i     (tick_10ms_i),
    .key_n_i    (key_mode_n_i),
    .press_o    (mode_stb),
    .pressed_o  (mode_pressed),
    .held_tick_o(mode_held_tick)
  );

  key_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb_inc (
    .clk        (clk),
    .aclr       (aclr),
    .tick_i     (tick_10ms_i),
    .key_n_i    (key_inc_n_i),
    .press_o    (inc_press),
    .pressed_o  (inc_pressed),
    .held_tick_o(inc_held_tick)
  );

  // Mode key needs only its press strobe.
  assign unused_mode_lvl = mode_pressed ^ mode_held_tick;

  // Auto-repeat: count held ticks; fire at REPEAT_DELAY then every REPEAT_PERIOD.
  logic [RepW-1:0] rep_cnt_q;
  logic            rep_fire;
  logic            inc_stb;

  assign rep_fire = inc_held_tick && (rep_cnt_q == RepW'(REPEAT_DELAY - 1));
  assign inc_stb  = inc_press | rep_fire;

  // Repeat counter, cleared while the key is released.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      rep_cnt_q <= '0;
    end else if (!inc_pressed) begin
      rep_cnt_q <= '0;
    end else if (inc_held_tick) begin
      rep_cnt_q <= rep_fire ? RepW'(REPEAT_DELAY - REPEAT_PERIOD) : rep_cnt_q + 1'b1;
    end
  end

  rtc_state_e        state_q;
  logic [7:0]        edit_min_q, edit_sec_q;
  logic              run_en_q, load_q, load_clr_cc_q;
  logic [7:0]        load_min_q, load_sec_q;
  logic [1:0]        blank_mask_q;
  logic [BlinkW-1:0] blink_cnt_q;
  logic              blink_ph_q;
  logic [ToW-1:0]    to_cnt_q;

  logic              in_set, blink_wrap, to_expire;
  logic [BlinkW-1:0] blink_entry;
  logic [ToW-1:0]    to_entry;

  assign in_set     = (state_q == StSetMin) || (state_q == StSetSec);
  assign blink_wrap = tick_10ms_i && (blink_cnt_q == BlinkW'(BLINK_TICKS - 1));
  assign to_expire  = tick_10ms_i && (to_cnt_q == ToW'(TIMEOUT_TICKS - 1));
  // A tick landing on a state entry is counted in the new state.
  assign blink_entry = BlinkW'(tick_10ms_i);
  assign to_entry    = ToW'(tick_10ms_i);

  // Edit FSM with its blink/timeout counters and registered outputs.
  // Later assignments in the case override the generic counter update.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q       <= StRun;
      edit_min_q    <= '0;
      edit_sec_q    <= '0;
      run_en_q      <= 1'b1;
      load_q        <= 1'b0;
      load_clr_cc_q <= 1'b0;
      load_min_q    <= '0;
      load_sec_q    <= '0;
      blank_mask_q  <= '0;
      blink_cnt_q   <= '0;
      blink_ph_q    <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      load_q        <= 1'b0;
      load_clr_cc_q <= 1'b0;
      if (in_set && tick_10ms_i) begin
        to_cnt_q <= to_cnt_q + 1'b1;
        if (blink_wrap) begin
          blink_cnt_q  <= '0;
          blink_ph_q   <= ~blink_ph_q;
          blank_mask_q <= (state_q == StSetMin) ? {~blink_ph_q, 1'b0} : {1'b0, ~blink_ph_q};
        end else begin
          blink_cnt_q <= blink_cnt_q + 1'b1;
        end
      end
      unique case (state_q)
        StRun: begin
          if (mode_stb) begin
            state_q      <= StSetMin;
            edit_min_q   <= cur_min_i;
            edit_sec_q   <= cur_sec_i;
            run_en_q     <= 1'b0;
            blink_cnt_q  <= blink_entry;
            blink_ph_q   <= 1'b0;
            to_cnt_q     <= to_entry;
            blank_mask_q <= '0;
          end
        end
        StSetMin: begin
          if (mode_stb) begin
            state_q      <= StSetSec;
            blink_cnt_q  <= blink_entry;
            blink_ph_q   <= 1'b0;
            to_cnt_q     <= to_entry;
            blank_mask_q <= '0;
          end else if (inc_stb) begin
            edit_min_q <= bcd_inc_wrap(edit_min_q);
            to_cnt_q   <= '0;
          end else if (to_expire) begin
            state_q      <= StRun;
            run_en_q     <= 1'b1;
            blink_cnt_q  <= '0;
            blink_ph_q   <= 1'b0;
            to_cnt_q     <= '0;
            blank_mask_q <= '0;
          end
        end
        StSetSec: begin
          if (mode_stb) begin
            state_q       <= StCommit;
            load_q        <= 1'b1;
            load_clr_cc_q <= 1'b1;
            load_min_q    <= edit_min_q;
            load_sec_q    <= edit_sec_q;
            blink_cnt_q   <= '0;
            blink_ph_q    <= 1'b0;
            to_cnt_q      <= '0;
            blank_mask_q  <= '0;
          end else if (inc_stb) begin
            edit_sec_q <= bcd_inc_wrap(edit_sec_q);
            to_cnt_q   <= '0;
          end else if (to_expire) begin
            state_q      <= StRun;
            run_en_q     <= 1'b1;
            blink_cnt_q  <= '0;
            blink_ph_q   <= 1'b0;
            to_cnt_q     <= '0;
            blank_mask_q <= '0;
          end
        end
        StCommit: begin
          state_q  <= StRun;
          run_en_q <= 1'b1;
        end
        default: begin
          state_q  <= StRun;
          run_en_q <= 1'b1;
        end
      endcase
    end
  end

  assign run_en_o      = run_en_q;
  assign load_o        = load_q;
  assign load_min_o    = load_min_q;
  assign load_sec_o    = load_sec_q;
  assign load_clr_cc_o = load_clr_cc_q;
  assign blank_mask_o  = blank_mask_q;
  assign mode_o        = state_q;

endmodule

// File: tb/tb_rtc_set_controller.sv
// Self-checking bench for rtc_set_controller: tick-level behavioural model,
// a table-driven edit sequence, hand-written corner cases and random keys.
module tb_rtc_set_controller;

  logic       clk = 1'b0;
  logic       aclr = 1'b0;
  logic       tick = 1'b0;
  logic       key_mode_n = 1'b1;
  logic       key_inc_n = 1'b1;
  logic [7:0] cur_min = 8'h00;
  logic [7:0] cur_sec = 8'h00;
  logic       run_en_o, load_o, load_clr_cc_o;
  logic [7:0] load_min_o, load_sec_o;
  logic [1:0] blank_mask_o, mode_o;

  rtc_set_controller dut (
    .clk          (clk),
    .aclr         (aclr),
    .tick_10ms_i  (tick),
    .key_mode_n_i (key_mode_n),
    .key_inc_n_i  (key_inc_n),
    .cur_min_i    (cur_min),
    .cur_sec_i    (cur_sec),
    .run_en_o     (run_en_o),
    .load_o       (load_o),
    .load_min_o   (load_min_o),
    .load_sec_o   (load_sec_o),
    .load_clr_cc_o(load_clr_cc_o),
    .blank_mask_o (blank_mask_o),
    .mode_o       (mode_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Load-pulse monitor.
  int         load_seen = 0;
  logic [7:0] seen_min = 8'h00;
  logic [7:0] seen_sec = 8'h00;
  always @(negedge clk) begin
    if (load_o) begin
      load_seen++;
      seen_min = load_min_o;
      seen_sec = load_sec_o;
      check("load_clr_cc_with_load", int'(load_clr_cc_o), 1);
    end
  end

  // ---------------- behavioural model (one step per 10 ms tick) ----------------
  localparam int Deb = 2, RepDelay = 50, RepPeriod = 10, Blink = 25, Timeout = 1000;

  int         m_state;          // 0 run, 1 editing minutes, 2 editing seconds
  logic [7:0] m_min, m_sec;
  int         m_to, m_bc;
  bit         m_ph;
  int         m_loads;
  logic [7:0] m_lmin, m_lsec;
  int         m_low[2];
  bit         m_seen[2], m_held[2];
  int         m_hold_ticks;

  task automatic model_reset();
    m_state = 0; m_min = 8'h00; m_sec = 8'h00; m_to = 0; m_bc = 0; m_ph = 0;
    m_hold_ticks = 0;
    for (int k = 0; k < 2; k++) begin
      m_low[k] = 0; m_seen[k] = 0; m_held[k] = 0;
    end
  endtask

  function automatic logic [7:0] m_bcd_inc(input logic [7:0] v);
    int t, u, d;
    t = int'(v[7:4]);
    u = int'(v[3:0]);
    if (t > 5 || u > 9) return 8'h00;
    d = (t * 10 + u + 1) % 60;
    return 8'((d / 10) * 16 + (d % 10));
  endfunction

  task automatic m_deb(input int k, input bit lvl, output bit press);
    press = 0;
    if (lvl) begin
      m_low[k] = 0; m_held[k] = 0; m_seen[k] = 1;
    end else begin
      m_low[k]++;
      if (m_seen[k] && !m_held[k] && m_low[k] >= Deb) begin
        m_held[k] = 1;
        press = 1;
      end
    end
  endtask

  task automatic model_tick(input bit mn, input bit in);
    bit pm, pi, rep, was_held;
    rep = 0;
    was_held = m_held[1];
    m_deb(0, mn, pm);
    m_deb(1, in, pi);
    if (was_held && m_held[1]) begin
      m_hold_ticks++;
      rep = (m_hold_ticks >= RepDelay) && ((m_hold_ticks - RepDelay) % RepPeriod == 0);
    end else begin
      m_hold_ticks = 0;
    end
    if (m_state != 0) begin
      m_to++;
      m_bc++;
      if (m_bc == Blink) begin m_ph = ~m_ph; m_bc = 0; end
      if (m_to == Timeout) begin m_state = 0; m_ph = 0; m_bc = 0; m_to = 0; end
    end
    if (pm) begin
      m_to = 0; m_bc = 0; m_ph = 0;
      if (m_state == 0) begin
        m_state = 1; m_min = cur_min; m_sec = cur_sec;
      end else if (m_state == 1) begin
        m_state = 2;
      end else begin
        m_state = 0; m_loads++; m_lmin = m_min; m_lsec = m_sec;
      end
    end else if (pi || rep) begin
      if (m_state == 1) begin m_min = m_bcd_inc(m_min); m_to = 0; end
      else if (m_state == 2) begin m_sec = m_bcd_inc(m_sec); m_to = 0; end
    end
  endtask

  function automatic int m_blank();
    if (m_state == 1) return m_ph ? 2 : 0;
    if (m_state == 2) return m_ph ? 1 : 0;
    return 0;
  endfunction

  // Apply key levels for one tick sample, then compare against the model.
  task automatic do_tick(input bit mn, input bit in);
    key_mode_n = mn;
    key_inc_n  = in;
    repeat (3) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (4) @(negedge clk);
    model_tick(mn, in);
    check("mode", int'(mode_o), m_state);
    check("run_en", int'(run_en_o), (m_state == 0) ? 1 : 0);
    check("blank_mask", int'(blank_mask_o), m_blank());
    check("load_count", load_seen, m_loads);
    if (m_loads > 0) begin
      check("load_min", int'(seen_min), int'(m_lmin));
      check("load_sec", int'(seen_sec), int'(m_lsec));
    end
  endtask

  task automatic ticks(input int n, input bit mn, input bit in);
    for (int i = 0; i < n; i++) do_tick(mn, in);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_run_en"}, int'(run_en_o), 1);
    check({tag, "_load"}, int'(load_o), 0);
    check({tag, "_clr_cc"}, int'(load_clr_cc_o), 0);
    check({tag, "_mode"}, int'(mode_o), 0);
    check({tag, "_blank"}, int'(blank_mask_o), 0);
    check({tag, "_load_min"}, int'(load_min_o), 0);
    check({tag, "_load_sec"}, int'(load_sec_o), 0);
  endtask

  // Table rows: hold the key levels for n ticks, then expect mode/run_en.
  typedef struct {
    int n;
    bit mode_n;
    bit inc_n;
    int exp_mode;
    int exp_run;
  } step_t;
  step_t tbl[$];

  task automatic add(input int n, input bit mn, input bit in, input int em, input int er);
    step_t s;
    s.n = n; s.mode_n = mn; s.inc_n = in; s.exp_mode = em; s.exp_run = er;
    tbl.push_back(s);
  endtask

  function automatic logic [7:0] rand_bcd();
    if ($urandom_range(0, 4) == 0) return 8'($urandom_range(0, 255));
    return 8'($urandom_range(0, 5) * 16 + $urandom_range(0, 9));
  endfunction

  int base;

  initial begin
    model_reset();
    m_loads = 0; m_lmin = 8'h00; m_lsec = 8'h00;

    // 1: reset values, then idle ticks.
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    aclr = 1'b1;
    ticks(10, 1, 1);
    check("idle_run_en", int'(run_en_o), 1);
    check("idle_mode", int'(mode_o), 0);
    check("idle_blank", int'(blank_mask_o), 0);
    check("idle_loads", load_seen, 0);

    // 2: table-driven edit 12:34 -> 15:36.
    cur_min = 8'h12; cur_sec = 8'h34;
    add(3, 0, 1, 1, 0); add(3, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin add(3, 1, 0, 1, 0); add(3, 1, 1, 1, 0); end
    add(3, 0, 1, 2, 0); add(3, 1, 1, 2, 0);
    for (int i = 0; i < 2; i++) begin add(3, 1, 0, 2, 0); add(3, 1, 1, 2, 0); end
    add(3, 0, 1, 0, 1); add(3, 1, 1, 0, 1);
    base = load_seen;
    foreach (tbl[i]) begin
      ticks(tbl[i].n, tbl[i].mode_n, tbl[i].inc_n);
      check("tbl_mode", int'(mode_o), tbl[i].exp_mode);
      check("tbl_run_en", int'(run_en_o), tbl[i].exp_run);
    end
    check("t2_one_load", load_seen - base, 1);
    check("t2_load_min", int'(seen_min), 8'h15);
    check("t2_load_sec", int'(seen_sec), 8'h36);

    // 3: auto-repeat across the 59 -> 00 wrap.
    cur_min = 8'h58; cur_sec = 8'h07;
    base = load_seen;
    ticks(3, 0, 1); ticks(3, 1, 1);
    ticks(70, 1, 0); ticks(3, 1, 1);
    ticks(3, 0, 1); ticks(3, 1, 1);
    ticks(3, 0, 1); ticks(3, 1, 1);
    check("t3_one_load", load_seen - base, 1);
    check("t3_load_min", int'(seen_min), 8'h01);
    check("t3_load_sec", int'(seen_sec), 8'h07);

    // 4: one-tick glitch ignored; simultaneous mode+inc advances without edit.
    cur_min = 8'h23; cur_sec = 8'h45;
    base = load_seen;
    ticks(3, 0, 1); ticks(3, 1, 1);
    ticks(1, 1, 0); ticks(3, 1, 1);
    check("t4_still_min", int'(mode_o), 1);
    ticks(3, 0, 0);
    check("t4_mode_wins", int'(mode_o), 2);
    ticks(3, 1, 1);
    ticks(3, 0, 1); ticks(3, 1, 1);
    check("t4_one_load", load_seen - base, 1);
    check("t4_load_min", int'(seen_min), 8'h23);
    check("t4_load_sec", int'(seen_sec), 8'h45);

    // 5: timeout from SET_SEC with seconds blink.
    cur_min = 8'h10; cur_sec = 8'h20;
    base = load_seen;
    ticks(3, 0, 1); ticks(3, 1, 1);
    ticks(2, 0, 1);
    check("t5_in_sec", int'(mode_o), 2);
    for (int k = 1; k <= 1000; k++) begin
      do_tick(1, 1);
      if (k == 24) check("t5_blank_24", int'(blank_mask_o), 0);
      if (k == 25) check("t5_blank_25", int'(blank_mask_o), 1);
      if (k == 50) check("t5_blank_50", int'(blank_mask_o), 0);
      if (k == 999) begin
        check("t5_mode_999", int'(mode_o), 2);
        check("t5_blank_999", int'(blank_mask_o), 1);
      end
    end
    check("t5_mode_timeout", int'(mode_o), 0);
    check("t5_run_en", int'(run_en_o), 1);
    check("t5_blank_off", int'(blank_mask_o), 0);
    check("t5_no_load", load_seen - base, 0);

    // 6: asynchronous reset mid SET_SEC.
    cur_min = 8'h31; cur_sec = 8'h41;
    base = load_seen;
    ticks(3, 0, 1); ticks(3, 1, 1);
    ticks(3, 0, 1); ticks(5, 1, 1);
    check("t6_in_sec", int'(mode_o), 2);
    @(negedge clk);
    #2 aclr = 1'b0;
    #1 check_reset_outputs("aclr");
    model_reset();
    @(negedge clk);
    aclr = 1'b1;
    ticks(10, 1, 1);
    check("t6_no_load", load_seen - base, 0);

    // Random key activity against the model.
    for (int s = 0; s < 250; s++) begin
      int len;
      bit mn, in;
      cur_min = rand_bcd();
      cur_sec = rand_bcd();
      mn  = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      in  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 6);
      if (!in && $urandom_range(0, 7) == 0) len = $urandom_range(45, 75);
      ticks(len, mn, in);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
